// File: rtl/motor_soft_start.sv
// motor_soft_start
// Soft-start / soft-stop PWM generator for the fan motor output stage.
// Instead of jumping straight to a fixed duty level, the applied duty is
// walked toward the target in STEP-sized increments, one step every
// RAMP_PERIODS PWM periods, and only ever updated at a period boundary.
// A level-sensitive emergency stop forces the output off on the next edge.
//
// Ports:
//   i_clk        core clock
//   i_reset      asynchronous, active-high reset
//   i_pwm_state  requested speed: 0 off, 1/2/3 speed levels, 4-7 treated as off
//   i_estop      level, active-high emergency stop
//   o_pwm        registered motor PWM
//   o_duty       currently applied duty, in counts
//   o_state      ramp state: 0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN, 3 HOLD
//   o_at_target  applied duty equals target and no emergency stop
module motor_soft_start #(
    parameter int PERIOD       = 1000,
    parameter int RAMP_PERIODS = 10,
    parameter int STEP         = 50,
    parameter int DUTY1        = 250,
    parameter int DUTY2        = 500,
    parameter int DUTY3        = 750
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_pwm_state,
    input  logic       i_estop,
    output logic       o_pwm,
    output logic [9:0] o_duty,
    output logic [1:0] o_state,
    output logic       o_at_target
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [9:0]    CNT_MAX  = 10'(PERIOD - 1);
    localparam logic [RW-1:0] RCNT_MAX = RW'(RAMP_PERIODS - 1);
    localparam logic [10:0]   STEP_W   = 11'(STEP);

    logic [9:0]    cnt_q;
    logic [RW-1:0] rcnt_q;
    logic [9:0]    duty_q;
    state_t        state_q;
    logic          pwm_q;

    logic          ptick;
    logic          stick;
    logic [RW-1:0] rcntInc;
    logic [9:0]    target;
    logic [10:0]   upSum;
    logic [9:0]    downDiff;
    logic [9:0]    dutyUp_d;
    logic [9:0]    dutyDown_d;

    assign ptick   = (cnt_q == CNT_MAX);
    assign stick   = ptick && (rcnt_q == RCNT_MAX);
    assign rcntInc = (rcnt_q == RCNT_MAX) ? '0 : rcnt_q + 1'b1;

    // Speed level to target duty; undefined levels mean "off".
    always_comb begin
        target = 10'd0;
        case (i_pwm_state)
            3'd1:    target = 10'(DUTY1);
            3'd2:    target = 10'(DUTY2);
            3'd3:    target = 10'(DUTY3);
            default: target = 10'd0;
        endcase
    end

    // Candidate duty for this cycle in each ramp direction. The up path
    // uses an 11-bit sum so duty+STEP cannot wrap before the clamp; the
    // down path clamps on the distance to target so it cannot underflow.
    // Both hold the current duty except on a step tick.
    always_comb begin
        upSum      = {1'b0, duty_q} + STEP_W;
        downDiff   = duty_q - target;
        dutyUp_d   = duty_q;
        dutyDown_d = duty_q;
        if (stick) begin
            dutyUp_d   = (upSum > {1'b0, target}) ? target : upSum[9:0];
            dutyDown_d = ({1'b0, downDiff} <= STEP_W) ? target : duty_q - STEP_W[9:0];
        end
    end

    // Free-running PWM period counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= 10'd0;
        end else begin
            cnt_q <= ptick ? 10'd0 : cnt_q + 10'd1;
        end
    end

    // Ramp FSM. Duty only moves on a step tick (which is always a period
    // tick), so a new duty starts cleanly at the next period. A reversal
    // mid-ramp keeps the ramp counter so the step cadence is not restarted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            duty_q  <= 10'd0;
            rcnt_q  <= '0;
        end else if (i_estop) begin
            state_q <= IDLE;
            duty_q  <= 10'd0;
            rcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_q <= 10'd0;
                    if (target != 10'd0) begin
                        state_q <= RAMP_UP;
                        rcnt_q  <= '0;
                    end
                end
                RAMP_UP: begin
                    if (ptick) rcnt_q <= rcntInc;
                    if (target < duty_q) begin
                        state_q <= RAMP_DOWN;
                    end else begin
                        duty_q <= dutyUp_d;
                        if (dutyUp_d == target) state_q <= (target == 10'd0) ? IDLE : HOLD;
                    end
                end
                RAMP_DOWN: begin
                    if (ptick) rcnt_q <= rcntInc;
                    if (target > duty_q) begin
                        state_q <= RAMP_UP;
                    end else begin
                        duty_q <= dutyDown_d;
                        if (dutyDown_d == target) state_q <= (target == 10'd0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (target > duty_q) begin
                        state_q <= RAMP_UP;
                        rcnt_q  <= '0;
                    end else if (target < duty_q) begin
                        state_q <= RAMP_DOWN;
                        rcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    duty_q  <= 10'd0;
                    rcnt_q  <= '0;
                end
            endcase
        end
    end

    // Registered PWM compare; lags the period counter by one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (cnt_q < duty_q) && !i_estop;
        end
    end

    assign o_pwm       = pwm_q;
    assign o_duty      = duty_q;
    assign o_state     = state_q;
    assign o_at_target = (duty_q == target) && !i_estop;

endmodule

// File: tb/tb_motor_soft_start.sv
// tb_motor_soft_start
// Directed bench for motor_soft_start with a short PWM period so each ramp
// step lands 40 cycles apart. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, so every position below is
// counted in rising edges since the last input change.
module tb_motor_soft_start;

    localparam int PERIOD       = 20;
    localparam int RAMP_PERIODS = 2;
    localparam int STEP         = 5;
    localparam int DUTY1        = 5;
    localparam int DUTY2        = 10;
    localparam int DUTY3        = 15;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_DOWN = 2;
    localparam int S_HOLD = 3;

    logic       i_clk;
    logic       i_reset;
    logic [2:0] i_pwm_state;
    logic       i_estop;
    logic       o_pwm;
    logic [9:0] o_duty;
    logic [1:0] o_state;
    logic       o_at_target;

    int testsRun    = 0;
    int testsFailed = 0;
    int highs;

    motor_soft_start #(
        .PERIOD(PERIOD), .RAMP_PERIODS(RAMP_PERIODS), .STEP(STEP),
        .DUTY1(DUTY1), .DUTY2(DUTY2), .DUTY3(DUTY3)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_pwm_state(i_pwm_state),
        .i_estop(i_estop),
        .o_pwm(o_pwm),
        .o_duty(o_duty),
        .o_state(o_state),
        .o_at_target(o_at_target)
    );

    // 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input int duty, input int st, input int atTarget);
        checkOutput({tag, "/duty"}, 32'(o_duty), 32'(duty));
        checkOutput({tag, "/state"}, 32'(o_state), 32'(st));
        checkOutput({tag, "/at"}, 32'(o_at_target), 32'(atTarget));
    endtask

    task automatic applyStimulus(input logic [2:0] st, input logic es);
        i_pwm_state = st;
        i_estop     = es;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic countHighs(input int n, output int h);
        h = 0;
        repeat (n) begin
            stepCycles(1);
            h += int'(o_pwm);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        applyStimulus(3'd0, 1'b0);
        stepCycles(3);
        checkStatus("reset", 0, S_IDLE, 1);
        checkOutput("reset/pwm", 32'(o_pwm), 32'd0);
        i_reset = 1'b0;

        // Idle with speed 0: nothing moves for 100 cycles.
        for (int i = 0; i < 10; i++) begin
            stepCycles(10);
            checkStatus("idle", 0, S_IDLE, 1);
            checkOutput("idle/pwm", 32'(o_pwm), 32'd0);
        end

        // 0 -> 3: steps of 5 every 40 cycles, landing on the period wrap.
        applyStimulus(3'd3, 1'b0);
        stepCycles(1);
        checkStatus("up3/start", 0, S_UP, 0);
        stepCycles(38);
        checkOutput("up3/pre5", 32'(o_duty), 32'd0);
        stepCycles(1);
        checkStatus("up3/5", 5, S_UP, 0);
        checkOutput("up3/lag", 32'(o_pwm), 32'd0);
        countHighs(20, highs);
        checkOutput("up3/highs5", 32'(highs), 32'd5);
        stepCycles(19);
        checkOutput("up3/pre10", 32'(o_duty), 32'd5);
        stepCycles(1);
        checkStatus("up3/10", 10, S_UP, 0);
        stepCycles(39);
        checkOutput("up3/pre15", 32'(o_duty), 32'd10);
        stepCycles(1);
        checkStatus("up3/hold", 15, S_HOLD, 1);
        countHighs(20, highs);
        checkOutput("hold15/highs", 32'(highs), 32'd15);

        // 15 -> 1: down through 10 to 5, then 0 ends in IDLE.
        applyStimulus(3'd1, 1'b0);
        stepCycles(1);
        checkStatus("dn1/start", 15, S_DOWN, 0);
        stepCycles(38);
        checkOutput("dn1/pre10", 32'(o_duty), 32'd15);
        stepCycles(1);
        checkStatus("dn1/10", 10, S_DOWN, 0);
        stepCycles(40);
        checkStatus("dn1/hold", 5, S_HOLD, 1);
        applyStimulus(3'd0, 1'b0);
        stepCycles(1);
        checkStatus("dn0/start", 5, S_DOWN, 0);
        stepCycles(38);
        checkOutput("dn0/pre0", 32'(o_duty), 32'd5);
        stepCycles(1);
        checkStatus("dn0/idle", 0, S_IDLE, 1);

        // Reverse at duty 10 toward 5: no overshoot, step keeps cadence.
        applyStimulus(3'd3, 1'b0);
        stepCycles(1);
        checkOutput("rev/up", 32'(o_state), 32'(S_UP));
        stepCycles(79);
        checkOutput("rev/at10", 32'(o_duty), 32'd10);
        applyStimulus(3'd1, 1'b0);
        stepCycles(1);
        checkStatus("rev/turn", 10, S_DOWN, 0);
        stepCycles(19);
        checkOutput("rev/mid", 32'(o_duty), 32'd10);
        stepCycles(19);
        checkOutput("rev/pre5", 32'(o_duty), 32'd10);
        stepCycles(1);
        checkStatus("rev/hold", 5, S_HOLD, 1);

        // Back up to 15, then a 3-cycle emergency stop mid-period.
        applyStimulus(3'd3, 1'b0);
        stepCycles(80);
        checkStatus("es/hold15", 15, S_HOLD, 1);
        stepCycles(10);
        applyStimulus(3'd3, 1'b1);
        #1;
        checkOutput("es/atcomb", 32'(o_at_target), 32'd0);
        stepCycles(1);
        checkStatus("es/stop", 0, S_IDLE, 0);
        checkOutput("es/pwm", 32'(o_pwm), 32'd0);
        stepCycles(2);
        checkStatus("es/held", 0, S_IDLE, 0);
        applyStimulus(3'd3, 1'b0);
        stepCycles(1);
        checkStatus("es/rel", 0, S_UP, 0);
        stepCycles(25);
        checkOutput("es/pre5", 32'(o_duty), 32'd0);
        stepCycles(1);
        checkOutput("es/5", 32'(o_duty), 32'd5);
        stepCycles(40);
        checkOutput("es/10", 32'(o_duty), 32'd10);
        stepCycles(40);
        checkStatus("es/hold", 15, S_HOLD, 1);

        // Down to 10, then speed code 6 ramps to off.
        applyStimulus(3'd2, 1'b0);
        stepCycles(40);
        checkStatus("s6/hold10", 10, S_HOLD, 1);
        applyStimulus(3'd6, 1'b0);
        stepCycles(1);
        checkStatus("s6/start", 10, S_DOWN, 0);
        stepCycles(39);
        checkOutput("s6/5", 32'(o_duty), 32'd5);
        stepCycles(40);
        checkStatus("s6/idle", 0, S_IDLE, 1);

        // Reset mid-ramp at counter position 7 clears everything at once.
        applyStimulus(3'd3, 1'b0);
        stepCycles(40);
        checkOutput("rst/5", 32'(o_duty), 32'd5);
        stepCycles(3);
        checkOutput("rst/pwmhi", 32'(o_pwm), 32'd1);
        stepCycles(4);
        i_reset = 1'b1;
        applyStimulus(3'd0, 1'b0);
        #1;
        checkStatus("rst/async", 0, S_IDLE, 1);
        checkOutput("rst/pwm", 32'(o_pwm), 32'd0);
        stepCycles(1);
        i_reset = 1'b0;
        applyStimulus(3'd1, 1'b0);
        stepCycles(39);
        checkOutput("rst/pre5", 32'(o_duty), 32'd0);
        stepCycles(1);
        checkStatus("rst/hold5", 5, S_HOLD, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/motor_soft_start.md
Name: motor_soft_start

Overview:
Soft-start/soft-stop PWM generator for the fan motor output stage. It consumes the speed state produced by the motor FSM. Instead of switching directly between fixed duty levels, it ramps the applied duty toward the target in fixed steps at PWM period boundaries. It also provides an immediate emergency stop. It sits downstream of the motor FSM, replaces the fixed PWM/MUX path, and drives the motor pin and status LEDs.

Parameters:
PERIOD, 1000, PWM period in i_clk cycles (1 ms at the 1 MHz core clock); 2 <= PERIOD <= 1023
RAMP_PERIODS, 10, PWM periods between successive duty steps; >= 1
STEP, 50, duty increment/decrement per step, in counts; >= 1
DUTY1, 250, target duty for speed state 1
DUTY2, 500, target duty for speed state 2
DUTY3, 750, target duty for speed state 3; DUTY1 < DUTY2 < DUTY3 <= PERIOD

Ports:
i_clk  input  1  core clock (1 MHz divided clock)
i_reset  input  1  asynchronous, active-high reset
i_pwm_state  input  3  requested speed: 0 off, 1/2/3 speed levels, 4-7 treated as 0
i_estop  input  1  level, active-high emergency stop
o_pwm  output  1  registered motor PWM
o_duty  output  10  currently applied duty, in counts
o_state  output  2  ramp FSM state: 0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN, 3 HOLD
o_at_target  output  1  high when o_duty == target and i_estop is low

Behaviour:
- Reset (async, active-high): period counter cnt=0, ramp counter rcnt=0, o_duty=0, o_pwm=0, o_state=IDLE, o_at_target=1 (target 0 == duty 0).
- Period counter: cnt counts 0..PERIOD-1 and wraps to 0. ptick = (cnt == PERIOD-1).
- Target: combinational lookup from i_pwm_state: 0->0, 1->DUTY1, 2->DUTY2, 3->DUTY3, 4..7->0.
- o_pwm is registered: o_pwm <= (cnt < o_duty) && !i_estop. It lags cnt by one cycle. Duty 0 gives constant low; duty PERIOD gives constant high.
- o_duty changes only on a ptick cycle, so the new duty first applies at cnt=0 of the next period. No partial periods or glitches.
- Ramp counter: rcnt increments on each ptick while in RAMP_UP or RAMP_DOWN and wraps at RAMP_PERIODS-1. stick = ptick && (rcnt == RAMP_PERIODS-1).
- FSM (registered), next state evaluated every cycle:
  - IDLE: duty 0, target 0. If target > 0, go to RAMP_UP and clear rcnt.
  - RAMP_UP: on stick, duty <= min(duty+STEP, target). If target < duty, go to RAMP_DOWN without clearing rcnt (reversal mid-ramp). When duty == target (including after a step), go to HOLD.
  - RAMP_DOWN: on stick, duty <= max(duty-STEP, target), computed with saturation so there is no underflow. If target > duty, go to RAMP_UP (rcnt kept). When duty == target, go to HOLD, or to IDLE if the target is 0.
  - HOLD: if target > duty, go to RAMP_UP; if target < duty, go to RAMP_DOWN. rcnt is cleared on either exit.
- First step after leaving IDLE/HOLD lands RAMP_PERIODS full periods later, at most one period of alignment slack.
- Arithmetic uses an 11-bit intermediate for duty+STEP; the result is clamped to target, so it never exceeds PERIOD.
- i_estop high:
  - Next clock edge: o_duty=0, o_state=IDLE, rcnt=0, o_pwm=0.
  - Held in IDLE while i_estop stays high, regardless of target.
  - On release, ramps up from 0 normally.
  - o_at_target=0 while i_estop is high.
- Target change during HOLD takes effect from the next cycle. i_pwm_state is assumed synchronous to i_clk; the FSM upstream is on the same clock.
- Reset asserted mid-ramp forces all reset values immediately, without waiting for a period boundary.

Test Plan:
Bench settings: PERIOD=20, RAMP_PERIODS=2, STEP=5, DUTY1=5, DUTY2=10, DUTY3=15.
- Reset, i_pwm_state=0 for 100 cycles -> o_pwm=0, o_duty=0, o_state=IDLE, o_at_target=1 throughout.
- i_pwm_state 0->3 -> o_state=RAMP_UP; o_duty steps 5, 10, 15, each 40 cycles apart, changing only on cnt=19; then HOLD, o_at_target=1, o_pwm high 15 of every 20 cycles.
- From HOLD at 15, set i_pwm_state=1 -> RAMP_DOWN, duty 10 then 5, HOLD; then set state 0 -> duty 0, o_state=IDLE.
- Ramp up to 3; at duty 10 switch to state 1 -> immediate RAMP_DOWN, next step duty 5, HOLD; no overshoot past 10.
- In HOLD at 15, pulse i_estop for 3 cycles -> o_pwm=0 and o_duty=0 next edge; after release, ramps 5, 10, 15 again.
- i_pwm_state=6 while holding at 10 -> ramps to 0 and ends in IDLE. Separately, assert i_reset mid-ramp at cnt=7 -> all outputs at reset values within the same cycle.
